// File: rtl/cpu_params_pkg.sv
// ----------------------------------------------------------------------------
// cpu_params
//   Shared sizing constants for the out-of-order backend.
//   Contents:
//     PRF_DEPTH / ARF_DEPTH / PRF_IDX / ID_WIDTH  - core-wide sizes
//     FL_DEPTH   free-list entries (PRF registers not held by the RRF)
//     FL_IDX_W   free-list array index width
//     FL_PTR_W   free-list pointer width (index plus one wrap bit)
//     ENQ_CNT_W  width of a per-cycle release count (0..ID_WIDTH)
// ----------------------------------------------------------------------------
package cpu_params;

    localparam int PRF_DEPTH = 64;
    localparam int ARF_DEPTH = 32;
    localparam int PRF_IDX   = $clog2(PRF_DEPTH);
    localparam int ID_WIDTH  = 2;

    localparam int FL_DEPTH  = PRF_DEPTH - ARF_DEPTH;
    localparam int FL_IDX_W  = $clog2(FL_DEPTH);
    localparam int FL_PTR_W  = FL_IDX_W + 1;
    localparam int ENQ_CNT_W = $clog2(ID_WIDTH + 1);

    typedef logic [PRF_IDX-1:0]  prf_idx_t;
    typedef logic [FL_PTR_W-1:0] fl_ptr_t;

endpackage

// File: rtl/fl_itf.sv
// ----------------------------------------------------------------------------
// Free-list interfaces.
//   id_fl_itf  : rename/dispatch <-> free list
//     valid     rename consumes free_idx this cycle
//     ready     free list non-empty
//     free_idx  PRF index at the head of the free list
//   rrf_fl_itf : retirement RAT -> free list
//     valid     per-lane release strobe
//     stale_idx per-lane PRF index being released
// ----------------------------------------------------------------------------
interface id_fl_itf;
    import cpu_params::*;

    logic     valid;
    logic     ready;
    prf_idx_t free_idx;

    modport fl (input valid, output ready, output free_idx);
    modport id (output valid, input ready, input free_idx);
endinterface

interface rrf_fl_itf;
    import cpu_params::*;

    logic [ID_WIDTH-1:0]                valid;
    logic [ID_WIDTH-1:0][PRF_IDX-1:0]   stale_idx;

    modport fl  (input valid, input stale_idx);
    modport rrf (output valid, output stale_idx);
endinterface

// File: rtl/free_list.sv
// ----------------------------------------------------------------------------
// free_list
//   Circular FIFO of free physical register indices. Hands out one index per
//   cycle to rename and takes back up to ID_WIDTH stale indices per cycle from
//   the retirement RAT. A flush makes the list full again in one cycle: the
//   FL_DEPTH entries sitting behind tail are exactly the non-RRF registers.
//
//   Ports:
//     clk       clock
//     rst       synchronous reset, active low
//     flush     backend flush (mispredict recovery)
//     from_id   id_fl_itf.fl  : valid in, ready/free_idx out
//     from_rrf  rrf_fl_itf.fl : per-lane valid/stale_idx in
//     err       sticky overflow/underflow flag
//
//   Build option: FREE_LIST_ASSERT_EN
//     defined   - excess release lanes on a full list are dropped, dequeue of
//                 an empty list is flagged; either sets err and calls $error.
//     undefined - err is tied low and no checking is done.
// ----------------------------------------------------------------------------
module free_list
    import cpu_params::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  flush,
    id_fl_itf.fl  from_id,
    rrf_fl_itf.fl from_rrf,
    output logic  err
);

    prf_idx_t entry [FL_DEPTH];

    fl_ptr_t head;
    fl_ptr_t tail;
    fl_ptr_t head_next;
    fl_ptr_t tail_next;

    logic                             empty;
    logic                             deq;
    logic [ENQ_CNT_W-1:0]             n_enq;
    logic [ID_WIDTH-1:0]              wr_en;
    logic [ID_WIDTH-1:0][FL_IDX_W-1:0] wr_addr;

`ifdef FREE_LIST_ASSERT_EN
    fl_ptr_t             count;
    logic [FL_PTR_W:0]   room;
    logic                overflow;
    logic                underflow;
`endif

    // Outputs come from registered pointers only; a release never bypasses
    // to the head in the same cycle.
    assign empty            = (head == tail);
    assign from_id.ready    = !empty;
    assign from_id.free_idx = entry[head[FL_IDX_W-1:0]];

    // A flush cancels the dequeue; the pointer is rebuilt from tail instead.
    assign deq = from_id.valid && !empty && !flush;

`ifdef FREE_LIST_ASSERT_EN
    assign count     = tail - head;
    // Slots available this cycle; a same-cycle dequeue frees its slot.
    assign room      = (FL_PTR_W+1)'(FL_DEPTH) - {1'b0, count}
                     + {{FL_PTR_W{1'b0}}, deq};
    assign underflow = from_id.valid && empty;
`endif

    // Compact accepted lanes in lane order: each accepted lane lands at
    // tail + (number of lower lanes already accepted). Index 0 is never
    // released since p0 is the hardwired zero register.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        n_enq   = '0;
        wr_en   = '0;
        wr_addr = '0;
`ifdef FREE_LIST_ASSERT_EN
        overflow = 1'b0;
`endif
        for (int l = 0; l < ID_WIDTH; l++) begin
            wr_en[l] = from_rrf.valid[l] && (from_rrf.stale_idx[l] != '0);
`ifdef FREE_LIST_ASSERT_EN
            if (wr_en[l] && !((FL_PTR_W+1)'(n_enq) < room)) begin
                wr_en[l] = 1'b0;
                overflow = 1'b1;
            end
`endif
            if (wr_en[l]) begin
                wr_addr[l] = tail[FL_IDX_W-1:0] + FL_IDX_W'(n_enq);
                n_enq      = n_enq + ENQ_CNT_W'(1);
            end
        end
    end

    assign tail_next = tail + FL_PTR_W'(n_enq);
    // After a flush the list is full: head sits FL_DEPTH behind the new tail.
    assign head_next = flush ? {~tail_next[FL_PTR_W-1], tail_next[FL_IDX_W-1:0]}
                             : head + FL_PTR_W'(deq);

    // NOTE: the array is reset on purpose - its initial contents are the
    // free registers ARF_DEPTH..PRF_DEPTH-1, not don't-cares.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head <= '0;
            tail <= {1'b1, {FL_IDX_W{1'b0}}};
            for (int i = 0; i < FL_DEPTH; i++) begin
                entry[i] <= prf_idx_t'(ARF_DEPTH + i);
            end
        end else begin
            head <= head_next;
            tail <= tail_next;
            for (int l = 0; l < ID_WIDTH; l++) begin
                if (wr_en[l]) begin
                    entry[wr_addr[l]] <= from_rrf.stale_idx[l];
                end
            end
        end
    end

`ifdef FREE_LIST_ASSERT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (overflow || underflow) begin
            err <= 1'b1;
            $error("free_list %s at %0t: head=%0h tail=%0h",
                   underflow ? "underflow" : "overflow", $time, head, tail);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
// ----------------------------------------------------------------------------
// tb_free_list
//   Directed scenarios followed by a randomized phase. The reference model is
//   a queue of free indices plus a queue of the last FL_DEPTH indices written
//   into the list (initial contents included); a flush makes the free list
//   equal to that history, oldest first.
// ----------------------------------------------------------------------------
module tb_free_list;
    import cpu_params::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic err;

    id_fl_itf  id_if ();
    rrf_fl_itf rrf_if ();

    free_list dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .from_id  (id_if),
        .from_rrf (rrf_if),
        .err      (err)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   freeq[$];
    int   hist[$];
    logic err_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        freeq.delete();
        hist.delete();
        for (int i = 0; i < FL_DEPTH; i++) begin
            freeq.push_back(ARF_DEPTH + i);
            hist.push_back(ARF_DEPTH + i);
        end
        err_m = 1'b0;
    endtask

    // Called at a negedge: applies inputs, checks outputs, advances the model,
    // and returns at the following negedge.
    task automatic cycle(input logic dv, input logic [1:0] rv,
                         input int i0, input int i1, input logic fl);
        int  lane_idx[2];
        int  room;
        logic deq_m;
        logic bad;
        id_if.valid         = dv;
        rrf_if.valid        = rv;
        rrf_if.stale_idx[0] = prf_idx_t'(i0);
        rrf_if.stale_idx[1] = prf_idx_t'(i1);
        flush               = fl;

        check("ready", 32'(id_if.ready), 32'(freeq.size() != 0));
        if (freeq.size() != 0) check("free_idx", 32'(id_if.free_idx), 32'(freeq[0]));
        check("err", 32'(err), 32'(err_m));

        bad   = dv && (freeq.size() == 0);
        deq_m = dv && (freeq.size() != 0) && !fl;
        if (deq_m) void'(freeq.pop_front());
        room = FL_DEPTH - freeq.size();
        lane_idx[0] = i0;
        lane_idx[1] = i1;
        for (int l = 0; l < 2; l++) begin
            if (rv[l] && lane_idx[l] != 0) begin
                if (room > 0) begin
                    freeq.push_back(lane_idx[l]);
                    hist.push_back(lane_idx[l]);
                    if (hist.size() > FL_DEPTH) void'(hist.pop_front());
                    room--;
                end else begin
                    bad = 1'b1;
                end
            end
        end
        if (fl) freeq = hist;
`ifdef FREE_LIST_ASSERT_EN
        if (bad) err_m = 1'b1;
`else
        if (bad) $display("note: illegal stimulus generated (bench bug)");
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        id_if.valid  = 1'b0;
        rrf_if.valid = '0;
        flush        = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        check("rst_ready", 32'(id_if.ready), 32'd1);
        check("rst_free_idx", 32'(id_if.free_idx), 32'(ARF_DEPTH));
        check("rst_err", 32'(err), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'b00, 0, 0, 1'b0);
    endtask

    initial begin
        int   dv_r, i0, i1, avail;
        logic [1:0] rv;
        logic fl;

        id_if.valid         = 1'b0;
        rrf_if.valid        = '0;
        rrf_if.stale_idx[0] = '0;
        rrf_if.stale_idx[1] = '0;
        @(negedge clk);

        // 1: drain the reset contents: 32, 33, ..., 63, then empty.
        do_reset();
        for (int i = 0; i < FL_DEPTH; i++) begin
            check("t1_idx", 32'(id_if.free_idx), 32'(ARF_DEPTH + i));
            cycle(1'b1, 2'b00, 0, 0, 1'b0);
        end
        check("t1_empty", 32'(id_if.ready), 32'd0);
        check("t1_err", 32'(err), 32'd0);

        // 2: two lanes released into an empty list; no same-cycle bypass.
        cycle(1'b0, 2'b11, 37, 40, 1'b0);
        check("t2_ready", 32'(id_if.ready), 32'd1);
        check("t2_first", 32'(id_if.free_idx), 32'd37);
        cycle(1'b1, 2'b00, 0, 0, 1'b0);
        check("t2_second", 32'(id_if.free_idx), 32'd40);
        cycle(1'b1, 2'b00, 0, 0, 1'b0);

        // 3: lane1-only release, then a release of p0 that must be dropped.
        cycle(1'b0, 2'b10, 0, 45, 1'b0);
        cycle(1'b0, 2'b01, 0, 0, 1'b0);
        check("t3_idx", 32'(id_if.free_idx), 32'd45);
        cycle(1'b1, 2'b00, 0, 0, 1'b0);
        check("t3_empty", 32'(id_if.ready), 32'd0);

        // 4: head at entry 31, then 40 cycles of dequeue + release of 50.
        do_reset();
        for (int i = 0; i < FL_DEPTH - 1; i++) cycle(1'b1, 2'b00, 0, 0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 2'b01, 50, 0, 1'b0);
        check("t4_idx", 32'(id_if.free_idx), 32'd50);
        cycle(1'b1, 2'b00, 0, 0, 1'b0);
        check("t4_empty", 32'(id_if.ready), 32'd0);

        // 5: ten dequeued, then flush with a release and an ignored dequeue.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 2'b00, 0, 0, 1'b0);
        cycle(1'b1, 2'b01, 33, 0, 1'b1);
        check("t5_after_flush", 32'(id_if.free_idx), 32'd33);
        for (int i = 0; i < FL_DEPTH; i++) cycle(1'b1, 2'b00, 0, 0, 1'b0);
        check("t5_drained", 32'(id_if.ready), 32'd0);

        // Randomized traffic with occasional flushes and one mid-run reset.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset();
            fl    = ($urandom_range(0, 15) == 0);
            dv_r  = (freeq.size() != 0) && ($urandom_range(0, 2) != 0);
            avail = FL_DEPTH - (freeq.size() - ((dv_r != 0 && !fl) ? 1 : 0));
            i0    = $urandom_range(0, PRF_DEPTH - 1);
            i1    = $urandom_range(0, PRF_DEPTH - 1);
            rv    = 2'($urandom_range(0, 3));
            if (rv[0] && i0 != 0) begin
                if (avail == 0) rv[0] = 1'b0;
                else avail--;
            end
            if (rv[1] && i1 != 0) begin
                if (avail == 0) rv[1] = 1'b0;
                else avail--;
            end
            cycle(dv_r != 0, rv, i0, i1, fl);
        end

`ifdef FREE_LIST_ASSERT_EN
        // 6: underflow sets a sticky err; overflow lanes leave entries intact.
        do_reset();
        for (int i = 0; i < FL_DEPTH; i++) cycle(1'b1, 2'b00, 0, 0, 1'b0);
        cycle(1'b1, 2'b00, 0, 0, 1'b0);
        check("t6_err_set", 32'(err), 32'd1);
        idle(3);
        check("t6_err_sticky", 32'(err), 32'd1);
        do_reset();
        cycle(1'b0, 2'b01, 7, 0, 1'b0);
        check("t6_err_ovf", 32'(err), 32'd1);
        for (int i = 0; i < FL_DEPTH; i++) begin
            check("t6_intact", 32'(id_if.free_idx), 32'(ARF_DEPTH + i));
            cycle(1'b1, 2'b00, 0, 0, 1'b0);
        end
        do_reset();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
